// File: rtl/arb4_pkg.sv
// arb4_pkg: shared constants, state type and one-hot helper for the 4-way round-robin arbiter
package arb4_pkg;
  localparam int NREQ = 4;
  localparam int HOLD_W = 8;
  typedef enum logic {IDLE, GRANT} state_t;
  function automatic logic [NREQ-1:0] onehot(input logic [1:0] i);
    return NREQ'(1) << i;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: first set bit of req scanning base, base+1, ... mod 4; in req[3:0], base[1:0]; out pick[1:0], any
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] base,
  output logic [1:0] pick,
  output logic       any
);
  logic [3:0] rot;
  logic [1:0] off;
  assign rot = 4'({req, req} >> base);
  assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : {2{rot[3]}};
  assign pick = base + off;
  assign any = |req;
endmodule

// File: rtl/arb4_onehot.sv
// arb4_onehot: round-robin arbiter with hold timeout; in clk, rst_n, req[3:0], lock; out registered gnt[3:0] (one-hot or zero), gnt_valid, gnt_id[1:0]
module arb4_onehot
  import arb4_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            lock,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_valid,
  output logic [1:0]      gnt_id
);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_MAX == 0 ? 0 : HOLD_MAX - 1);
  state_t state;
  logic [1:0] ptr, owner, base, pick;
  logic [HOLD_W-1:0] hold_cnt;
  logic [NREQ-1:0] cand;
  logic any, timeout, rearb;
  assign cand = req & ~gnt;
  assign base = state == GRANT ? owner + 2'd1 : ptr;
  assign timeout = HOLD_MAX != 0 && hold_cnt == HOLD_TOP && !lock && any;
  assign rearb = state == IDLE || !req[owner] || timeout;
  rr_pick4 u_pick (
    .req (cand),
    .base(base),
    .pick(pick),
    .any (any)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      hold_cnt <= '0;
      gnt <= '0;
      gnt_valid <= 1'b0;
      gnt_id <= '0;
    end else if (rearb) begin
      ptr <= state == GRANT ? owner + 2'd1 : ptr;
      state <= any ? GRANT : IDLE;
      owner <= any ? pick : owner;
      gnt <= any ? onehot(pick) : '0;
      gnt_valid <= any;
      gnt_id <= any ? pick : 2'd0;
      hold_cnt <= '0;
    end else
      hold_cnt <= hold_cnt == HOLD_TOP ? hold_cnt : hold_cnt + 1'b1;
endmodule

// File: tb/tb_arb4_onehot.sv
// tb_arb4_onehot: table-driven directed sequences plus randomized checking against a behavioural arbiter model
module tb_arb4_onehot;
  localparam int HM = 8;
  logic clk, rst_n, lock, gnt_valid;
  logic [3:0] req, gnt;
  logic [1:0] gnt_id;
  int n_cmp, n_err;
  int m_busy, m_own, m_ptr, m_held;
  int wt[4];
  bit wait_on;
  typedef struct {
    bit rst;
    logic [3:0] req;
    logic lock;
    int n;
    logic [3:0] gnt;
  } vec_t;
  vec_t tbl[$];

  arb4_onehot #(.HOLD_MAX(HM)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .lock(lock),
    .gnt(gnt),
    .gnt_valid(gnt_valid),
    .gnt_id(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_own = 0;
    m_ptr = 0;
    m_held = 0;
  endtask

  // m_held counts grant cycles so far; the owner may be preempted once it has had HM of them
  task automatic model_step(input logic [3:0] r, input logic l);
    int p;
    logic [3:0] others;
    others = r & ~(4'b0001 << m_own);
    if (m_busy == 0) begin
      p = first_from(r, m_ptr);
      if (p >= 0) begin
        m_busy = 1;
        m_own = p;
        m_held = 1;
      end
    end else if (!r[m_own]) begin
      m_ptr = (m_own + 1) % 4;
      p = first_from(r, m_ptr);
      if (p >= 0) begin
        m_own = p;
        m_held = 1;
      end else m_busy = 0;
    end else if (HM != 0 && m_held >= HM && !l && others != 0) begin
      m_ptr = (m_own + 1) % 4;
      m_own = first_from(others, m_ptr);
      m_held = 1;
    end else m_held++;
  endtask

  task automatic cyc(input logic [3:0] r, input logic l);
    logic [3:0] eg;
    req = r;
    lock = l;
    if (wait_on) begin
      for (int b = 0; b < 4; b++) wt[b] = (r[b] && !gnt[b] && gnt != 0) ? wt[b] + 1 : 0;
      n_cmp++;
      for (int b = 0; b < 4; b++)
        if (wt[b] > 3 * HM) begin
          n_err++;
          $display("FAIL wait_bound: source %0d waited %0d cycles, limit %0d", b, wt[b], 3 * HM);
        end
    end
    @(posedge clk);
    model_step(r, l);
    #1;
    eg = m_busy != 0 ? 4'b0001 << m_own : 4'b0000;
    chk("gnt", gnt, eg);
    chk("gnt_valid", gnt_valid, m_busy != 0);
    chk("gnt_id", gnt_id, m_busy != 0 ? m_own : 0);
    chk("onehot0", $onehot0(gnt), 1);
    chk("id_vs_gnt", gnt_valid ? 4'b0001 << gnt_id : 4'b0000, gnt);
  endtask

  task automatic mid_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_gnt", gnt, 0);
    chk("async_rst_valid", gnt_valid, 0);
    chk("async_rst_id", gnt_id, 0);
    model_reset();
    req = 4'b0000;
    lock = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic l;
    n_cmp = 0;
    n_err = 0;
    wait_on = 0;
    rst_n = 1'b0;
    req = 4'b0000;
    lock = 1'b0;
    model_reset();
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 8, 4'b0001});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 8, 4'b0010});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 8, 4'b0100});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 8, 4'b1000});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 1, 4'b0001});
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 50, 4'b0100});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1, 4'b0000});
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 1, 4'b0010});
    tbl.push_back('{1'b0, 4'b0110, 1'b0, 1, 4'b0010});
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 1, 4'b0100});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 2, 4'b0000});
    tbl.push_back('{1'b0, 4'b0011, 1'b1, 28, 4'b0001});
    tbl.push_back('{1'b0, 4'b0011, 1'b0, 1, 4'b0010});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1, 4'b0000});
    tbl.push_back('{1'b0, 4'b1000, 1'b0, 3, 4'b1000});
    tbl.push_back('{1'b1, 4'b1000, 1'b0, 1, 4'b1000});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1, 4'b0000});
    tbl.push_back('{1'b0, 4'b1001, 1'b0, 1, 4'b0001});
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", gnt, 0);
    chk("reset_valid", gnt_valid, 0);
    chk("reset_id", gnt_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < tbl.size(); v++) begin
      if (tbl[v].rst) mid_reset();
      for (int k = 0; k < tbl[v].n; k++) begin
        cyc(tbl[v].req, tbl[v].lock);
        chk($sformatf("table[%0d].%0d", v, k), gnt, tbl[v].gnt);
      end
    end
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      if (c == 5000) begin
        wait_on = 1;
        for (int b = 0; b < 4; b++) wt[b] = 0;
      end
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 9) == 0) r[b] = ~r[b];
      l = c < 5000 && $urandom_range(0, 5) == 0;
      cyc(r, l);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
